serial_alu_ctrl: RTL

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

---
 rtl/serial_alu_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/serial_alu_ctrl.sv
// rtl/serial_alu_ctrl.sv - bit-serial ALU with IDLE/SHIFT/DONE control FSM
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       S,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             Z
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_last;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_f;
  logic             r_cout;
  logic             r_z;

  logic w_op;
  logic w_bit;
  logic w_cnext;
  logic w_cinit;

  // Carry preload: INC and SUB start with an injected +1, everything else with 0.
  assign w_cinit = (S == 3'b000) || (S == 3'b010);

  // One result bit from the current LSBs of the operand shifters and the carry.
  always_comb begin
    w_op    = 1'b0;
    w_bit   = 1'b0;
    w_cnext = 1'b0;
    if (r_s[2]) begin
      case (r_s[1:0])
        2'b00:   w_bit = r_a[0] & r_b[0];
        2'b01:   w_bit = r_a[0] | r_b[0];
        2'b10:   w_bit = r_a[0] ^ r_b[0];
        default: w_bit = ~r_a[0];
      endcase
    end else if (r_s[1:0] == 2'b00) begin
      w_bit   = r_a[0] ^ r_carry;
      w_cnext = r_a[0] & r_carry;
    end else begin
      case (r_s[1:0])
        2'b01:   w_op = r_b[0];
        2'b10:   w_op = ~r_b[0];
        default: w_op = 1'b1;
      endcase
      w_bit   = r_a[0] ^ w_op ^ r_carry;
      w_cnext = (r_a[0] & w_op) | (r_carry & (r_a[0] ^ w_op));
    end
  end

  // Control FSM, operand shifters and result registers.
  // The extra SHIFT cycle flagged by r_last publishes the assembled result,
  // so the counter never has to count past WIDTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_last  <= 1'b0;
      r_res   <= '0;
      r_f     <= '0;
      r_cout  <= 1'b0;
      r_z     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_s     <= S;
            r_cnt   <= '0;
            r_carry <= w_cinit;
            r_last  <= 1'b0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!r_last) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= {w_bit, r_res[WIDTH-1:1]};
            r_carry <= w_cnext;
            if (r_cnt == LAST_BIT) begin
              r_last <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else begin
            r_f     <= r_res;
            r_cout  <= r_carry;
            r_z     <= (r_res == '0);
            r_last  <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign F    = r_f;
  assign Cout = r_cout;
  assign Z    = r_z;

endmodule
